inst_rom_arbiter: RTL and testbench

Two-port arbiter that shares the single combinational instruction ROM between the fetch stage (IF port) and a data-side read port (D port, used for loads from the code region and for debug reads). Grants at most one ROM access per cycle with round-robin priority on conflict. Registers the ROM output and returns it one cycle after the grant. Raises per-port stall requests toward the pipeline control block.

---
 rtl/inst_rom_arbiter.sv | 89 ++++++++
 tb/tb_inst_rom_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_arbiter.sv
// Two-port round-robin arbiter sharing the instruction ROM between
// the fetch port and a data-side read port, with registered read data.
module inst_rom_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    output logic              stallreq_if,
    output logic              stallreq_d,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic last_win;
    logic conflict;
    logic d_mis;

    assign conflict = if_req && d_req && !rst;
    assign d_mis    = (d_addr[1:0] != 2'b00);

    // last_win: 0 = IF won the previous conflict, 1 = D won it
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (if_req && (!d_req || last_win))
                if_gnt = 1'b1;
            if (d_req && (!if_req || !last_win))
                d_gnt = 1'b1;
        end
    end

    always_comb begin
        rom_ce   = 1'b0;
        rom_addr = '0;
        if (if_gnt) begin
            rom_ce   = 1'b1;
            rom_addr = if_addr;
        end else if (d_gnt && !d_mis) begin
            rom_ce   = 1'b1;
            rom_addr = d_addr;
        end
    end

    assign stallreq_if = !rst && if_req && !if_gnt;
    assign stallreq_d  = !rst && d_req && !d_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid    <= 1'b0;
            d_rvalid     <= 1'b0;
            d_err        <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            conflict_cnt <= '0;
            last_win     <= 1'b1;
        end else begin
            if_rvalid <= if_gnt;
            d_rvalid  <= d_gnt;
            d_err     <= d_gnt && d_mis;
            if (if_gnt)
                if_rdata <= rom_inst;
            // misaligned D reads never touch the ROM and return zero
            if (d_gnt)
                d_rdata <= d_mis ? '0 : rom_inst;
            if (conflict) begin
                last_win <= d_gnt;
                if (conflict_cnt != {CNT_W{1'b1}})
                    conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Self-checking bench for inst_rom_arbiter: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_inst_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req;
    logic [31:0] if_addr, d_addr;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err;
    logic [31:0] if_rdata, d_rdata;
    logic        rom_ce;
    logic [31:0] rom_addr, rom_inst;
    logic        stallreq_if, stallreq_d;
    logic [3:0]  conflict_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rom [0:63];

    always #5 clk = ~clk;

    assign rom_inst = rom_ce ? rom[rom_addr[7:2]] : 32'hBAD0BAD0;

    inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .stallreq_if(stallreq_if), .stallreq_d(stallreq_d),
        .conflict_cnt(conflict_cnt)
    );

    // reference model: round-robin by "who lost the last conflict"
    logic        m_last_win = 1'b1;
    int          m_cnt      = 0;
    logic        m_if_rv    = 1'b0;
    logic        m_d_rv     = 1'b0;
    logic        m_d_err    = 1'b0;
    logic [31:0] m_if_rd    = '0;
    logic [31:0] m_d_rd     = '0;
    logic        e_ig, e_dg, e_mis, e_ce;
    logic [31:0] e_addr;

    always_comb begin
        e_mis  = (d_addr[1:0] != 2'b00);
        e_ig   = !rst && if_req && (!d_req || m_last_win);
        e_dg   = !rst && d_req && (!if_req || !m_last_win);
        e_ce   = e_ig || (e_dg && !e_mis);
        e_addr = e_ig ? if_addr : (e_dg && !e_mis) ? d_addr : 32'h0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_last_win <= 1'b1;
            m_cnt      <= 0;
            m_if_rv    <= 1'b0;
            m_d_rv     <= 1'b0;
            m_d_err    <= 1'b0;
            m_if_rd    <= '0;
            m_d_rd     <= '0;
        end else begin
            m_if_rv <= e_ig;
            m_d_rv  <= e_dg;
            m_d_err <= e_dg && e_mis;
            if (e_ig) m_if_rd <= rom[if_addr[7:2]];
            if (e_dg) m_d_rd <= e_mis ? 32'h0 : rom[d_addr[7:2]];
            if (if_req && d_req) begin
                m_last_win <= e_dg;
                if (m_cnt < 15) m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic ir,
                         input logic [31:0] ia, input logic dr,
                         input logic [31:0] da);
        rst = r; if_req = ir; if_addr = ia; d_req = dr; d_addr = da;
    endtask

    task automatic test_reset();
        drive(1, 1, 32'h8, 1, 32'h10);
        #1;
        checks++;
        if ({if_gnt, d_gnt, rom_ce, stallreq_if, stallreq_d} !== 5'b0) begin
            failures++;
            $display("FAIL reset_comb got=%b want=00000",
                     {if_gnt, d_gnt, rom_ce, stallreq_if, stallreq_d});
        end
        tick();
        tick();
        checks++;
        if ({if_rvalid, d_rvalid, d_err} !== 3'b0 || if_rdata !== 0 ||
            d_rdata !== 0 || conflict_cnt !== 0) begin
            failures++;
            $display("FAIL reset_regs rv=%b%b err=%b ird=%h drd=%h cnt=%0d want zeros",
                     if_rvalid, d_rvalid, d_err, if_rdata, d_rdata, conflict_cnt);
        end
    endtask

    task automatic test_solo_fetch();
        drive(0, 1, 32'h8, 0, 32'h0);
        #1;
        checks++;
        if (if_gnt !== 1 || rom_ce !== 1 || rom_addr !== 32'h8) begin
            failures++;
            $display("FAIL solo_grant gnt=%b ce=%b addr=%h want 1 1 00000008",
                     if_gnt, rom_ce, rom_addr);
        end
        tick();
        drive(0, 0, 32'h0, 0, 32'h0);
        checks++;
        if (if_rvalid !== 1 || if_rdata !== 32'h34011100 || d_rvalid !== 0) begin
            failures++;
            $display("FAIL solo_data rv=%b rd=%h drv=%b want 1 34011100 0",
                     if_rvalid, if_rdata, d_rvalid);
        end
    endtask

    task automatic test_conflict();
        drive(1, 0, 0, 0, 0);
        tick();
        for (int c = 0; c < 4; c++) begin
            logic w_if;
            w_if = (c % 2 == 0);
            drive(0, 1, 32'h0, 1, 32'h10);
            #1;
            checks++;
            if (if_gnt !== w_if || d_gnt !== !w_if ||
                stallreq_d !== w_if || stallreq_if !== !w_if) begin
                failures++;
                $display("FAIL conflict_c%0d gnt=%b%b stall=%b%b want gnt=%b%b",
                         c, if_gnt, d_gnt, stallreq_if, stallreq_d, w_if, !w_if);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (conflict_cnt !== 4'd4) begin
            failures++;
            $display("FAIL conflict_cnt got=%0d want=4", conflict_cnt);
        end
    endtask

    task automatic test_misaligned();
        drive(0, 0, 32'h0, 1, 32'h13);
        #1;
        checks++;
        if (d_gnt !== 1 || rom_ce !== 0 || rom_addr !== 0) begin
            failures++;
            $display("FAIL mis_grant gnt=%b ce=%b addr=%h want 1 0 0",
                     d_gnt, rom_ce, rom_addr);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (d_rvalid !== 1 || d_err !== 1 || d_rdata !== 0 ||
            if_rdata !== rom[0]) begin
            failures++;
            $display("FAIL mis_data rv=%b err=%b drd=%h ird=%h want 1 1 0 %h",
                     d_rvalid, d_err, d_rdata, if_rdata, rom[0]);
        end
        tick();
        checks++;
        if (d_rvalid !== 0 || d_err !== 0) begin
            failures++;
            $display("FAIL mis_clear rv=%b err=%b want 0 0", d_rvalid, d_err);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 32'h4, 0, 0);
        #1;
        checks++;
        if (if_gnt !== 1) begin
            failures++;
            $display("FAIL rmid_grant gnt=%b want 1", if_gnt);
        end
        tick();
        drive(1, 0, 0, 0, 0);
        checks++;
        if (if_rvalid !== 1 || if_rdata !== rom[1]) begin
            failures++;
            $display("FAIL rmid_n1 rv=%b rd=%h want 1 %h", if_rvalid, if_rdata, rom[1]);
        end
        tick();
        checks++;
        if (if_rvalid !== 0 || if_rdata !== 0 || conflict_cnt !== 0) begin
            failures++;
            $display("FAIL rmid_n2 rv=%b rd=%h cnt=%0d want 0 0 0",
                     if_rvalid, if_rdata, conflict_cnt);
        end
        drive(0, 1, 32'h0, 1, 32'h10);
        #1;
        checks++;
        if (if_gnt !== 1 || d_gnt !== 0) begin
            failures++;
            $display("FAIL rmid_first_win gnt=%b%b want 10", if_gnt, d_gnt);
        end
        tick();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        drive(1, 0, 0, 0, 0);
        tick();
        for (int c = 0; c < 20; c++) begin
            logic w_if;
            w_if = (c % 2 == 0);
            drive(0, 1, 32'h4 * (c % 8), 1, 32'h40 + 32'h4 * c);
            #1;
            checks++;
            if (if_gnt !== w_if || d_gnt !== !w_if) begin
                failures++;
                $display("FAIL sat_alt_c%0d gnt=%b%b want %b%b",
                         c, if_gnt, d_gnt, w_if, !w_if);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (conflict_cnt !== 4'hF) begin
            failures++;
            $display("FAIL sat_cnt got=%0d want=15", conflict_cnt);
        end
    endtask

    task automatic test_data_hold();
        drive(0, 0, 0, 1, 32'h20);
        tick();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (d_rvalid !== 1 || d_err !== 0 || d_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL hold_first rv=%b err=%b rd=%h want 1 0 deadbeef",
                     d_rvalid, d_err, d_rdata);
        end
        for (int c = 0; c < 7; c++) begin
            if (c >= 2) drive(0, 1, 32'h4 * (c + 1), 0, 0);
            tick();
            checks++;
            if (d_rvalid !== 0 || d_rdata !== 32'hDEADBEEF) begin
                failures++;
                $display("FAIL hold_c%0d rv=%b rd=%h want 0 deadbeef",
                         c, d_rvalid, d_rdata);
            end
        end
        drive(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 29) == 0),
                  $urandom_range(0, 1),
                  {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                  $urandom_range(0, 1),
                  32'($urandom_range(0, 255)));
            #1;
            checks++;
            if (if_gnt !== e_ig || d_gnt !== e_dg || rom_ce !== e_ce ||
                rom_addr !== e_addr ||
                stallreq_if !== (!rst && if_req && !e_ig) ||
                stallreq_d !== (!rst && d_req && !e_dg)) begin
                failures++;
                $display("FAIL rnd_comb_c%0d gnt=%b%b ce=%b addr=%h want %b%b %b %h",
                         c, if_gnt, d_gnt, rom_ce, rom_addr, e_ig, e_dg, e_ce, e_addr);
            end
            tick();
            checks++;
            if (if_rvalid !== m_if_rv || d_rvalid !== m_d_rv ||
                d_err !== m_d_err || if_rdata !== m_if_rd ||
                d_rdata !== m_d_rd || 32'(conflict_cnt) !== m_cnt) begin
                failures++;
                $display("FAIL rnd_regs_c%0d rv=%b%b err=%b ird=%h drd=%h cnt=%0d want %b%b %b %h %h %0d",
                         c, if_rvalid, d_rvalid, d_err, if_rdata, d_rdata,
                         conflict_cnt, m_if_rv, m_d_rv, m_d_err,
                         m_if_rd, m_d_rd, m_cnt);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[2] = 32'h34011100;
        rom[8] = 32'hDEADBEEF;
        drive(1, 0, 0, 0, 0);
        test_reset();
        test_solo_fetch();
        test_conflict();
        test_misaligned();
        test_reset_mid();
        test_saturation();
        test_data_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
